bus_word_receiver: RTL

BUS_WORD_RECEIVER -- requirements
Module: bus_word_receiver

---
 rtl/bus_word_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bus_word_receiver.sv
// ---------------------------------------------------------------------------
// bus_word_receiver
//
// Purpose:
//   Captures a stream of {addr, payload} bus words into a small register
//   file indexed by addr, tracks whether the source kept its expected
//   incrementing address order, counts accepted words and sequence errors,
//   and flags the end of each burst with a one-cycle frame_done pulse.
//   A registered read port returns a stored payload plus a "written since
//   the last clear" bit.
//
// Ports:
//   clk        in   single clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   valid      in   data holds a word to capture this cycle (no backpressure)
//   data       in   {addr[ADDR_W-1:0], payload[PAYLOAD_W-1:0]}
//   clr        in   synchronous clear of written bits, counters and flags
//   rd_en      in   read request
//   rd_addr    in   read index
//   rd_data    out  registered read payload (held when rd_en=0)
//   rd_hit     out  registered written bit of the read entry
//   rd_ack     out  one-cycle strobe, high when rd_data/rd_hit are new
//   word_count out  accepted word count, saturating at 16'hFFFF
//   err_count  out  sequence error count, saturating at 8'hFF
//   seq_err    out  sticky sequence error flag
//   frame_done out  one-cycle pulse after each burst ends
//   busy       out  high while a burst is being received
// ---------------------------------------------------------------------------
module bus_word_receiver #(
  parameter int ADDR_W    = 4,
  parameter int PAYLOAD_W = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [ADDR_W+PAYLOAD_W-1:0] data,
  input  logic                        clr,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [PAYLOAD_W-1:0]        rd_data,
  output logic                        rd_hit,
  output logic                        rd_ack,
  output logic [15:0]                 word_count,
  output logic [7:0]                  err_count,
  output logic                        seq_err,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // The source always opens with addr=1, so that is where tracking restarts.
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]    word_addr;
  logic [PAYLOAD_W-1:0] word_payload;
  logic [ADDR_W-1:0]    addr_inc;
  logic [ADDR_W-1:0]    exp_addr;
  logic                 capture;
  logic                 addr_match;

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     written;

  // Field split of the incoming word; addr occupies the top bits.
  assign word_addr    = data[ADDR_W+PAYLOAD_W-1 -: ADDR_W];
  assign word_payload = data[PAYLOAD_W-1:0];

  // Natural wrap of the ADDR_W-bit add gives the modulo-2^ADDR_W successor.
  assign addr_inc = word_addr + ADDR_W'(1);

  // clr wins over valid, so a word presented alongside clr is dropped.
  assign capture    = valid && !clr;
  assign addr_match = (word_addr == exp_addr);

  // State register for the burst tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Burst tracker next state and outputs. DONE always lasts exactly one
  // cycle; a word arriving in DONE starts the next burst straight away while
  // frame_done for the previous burst is still shown.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          state_next = RECV;
        end
      end
      RECV: begin
        busy = 1'b1;
        if (!valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = valid ? RECV : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (clr) begin
      state_next = IDLE;
    end
  end

  // Expected-address tracking, counters and the sticky error flag. An
  // out-of-order word is still stored; tracking simply resynchronises to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr   <= FIRST_ADDR;
      word_count <= 16'h0000;
      err_count  <= 8'h00;
      seq_err    <= 1'b0;
    end else if (clr) begin
      exp_addr   <= FIRST_ADDR;
      word_count <= 16'h0000;
      err_count  <= 8'h00;
      seq_err    <= 1'b0;
    end else if (capture) begin
      exp_addr <= addr_inc;
      if (word_count != 16'hFFFF) begin
        word_count <= word_count + 16'd1;
      end
      if (!addr_match) begin
        seq_err <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  // Written bits are the only part of the store that reset and clr touch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else if (clr) begin
      written <= '0;
    end else if (capture) begin
      written[word_addr] <= 1'b1;
    end
  end

  // Payload storage has no reset; stale contents are masked by written.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[word_addr] <= word_payload;
    end
  end

  // Registered read port. Sampling mem/written before this edge's write
  // lands gives old-data behaviour on a same-index collision. A read that
  // coincides with clr still completes, but reports the entry as unwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
      rd_ack  <= 1'b0;
    end else begin
      rd_ack <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
        rd_hit  <= clr ? 1'b0 : written[rd_addr];
      end
    end
  end

endmodule
